// File: rtl/voq_switch_rr.sv
// voq_switch_rr: input-queued packet switch with per-input virtual output
// queues and a single-iteration iSLIP round-robin scheduler.
//
// Handshake semantics (all ports): a word moves on a rising edge where
// valid & ready are both high. valid never waits on ready. in_ready is
// combinational from the dest field and the VOQ counts. out_valid and
// out_data come straight from registers. out_data is held while
// out_valid & !out_ready.
//
// Optional feature macro: VOQ_FULL_DROP_EN. When it is defined, in_ready
// is tied high, a word for a full VOQ is discarded, and the saturating
// per-input drop_cnt port is present.
module voq_switch_rr #(
  parameter int PORT_NUB   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [PORT_NUB*($clog2(PORT_NUB)+DATA_WIDTH)-1:0]    in_data,
  input  logic [PORT_NUB-1:0]                                  in_valid,
  output logic [PORT_NUB-1:0]                                  in_ready,
  output logic [PORT_NUB*($clog2(PORT_NUB)+DATA_WIDTH)-1:0]    out_data,
  output logic [PORT_NUB-1:0]                                  out_valid,
  input  logic [PORT_NUB-1:0]                                  out_ready,
  output logic [PORT_NUB*PORT_NUB-1:0]                         voq_empty
`ifdef VOQ_FULL_DROP_EN
  ,
  output logic [PORT_NUB*16-1:0]                               drop_cnt
`endif
);

  localparam int WIDTH_SEL = $clog2(PORT_NUB);
  localparam int WORD_W    = WIDTH_SEL + DATA_WIDTH;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int NQ        = PORT_NUB * PORT_NUB;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // VOQ(i,d) lives at flat index i*PORT_NUB+d
  logic [DATA_WIDTH-1:0] mem    [NQ][DEPTH];
  logic [PTR_W-1:0]      wr_ptr [NQ];
  logic [PTR_W-1:0]      rd_ptr [NQ];
  logic [PTR_W:0]        cnt    [NQ];

  logic [WIDTH_SEL-1:0]  g_ptr   [PORT_NUB];
  logic [WIDTH_SEL-1:0]  a_ptr   [PORT_NUB];
  logic [WORD_W-1:0]     out_reg [PORT_NUB];
  logic [PORT_NUB-1:0]   out_vld;

  logic [WIDTH_SEL-1:0]  dest    [PORT_NUB];
  logic [DATA_WIDTH-1:0] payload [PORT_NUB];
  logic [PORT_NUB-1:0]   sel_full;
  logic [PORT_NUB-1:0]   push;
  logic [NQ-1:0]         push_q;
  logic [NQ-1:0]         pop_q;
  logic [PORT_NUB-1:0]   slot_free;
  logic [PORT_NUB-1:0]   req [PORT_NUB];   // req[i][o]
  logic [PORT_NUB-1:0]   gnt [PORT_NUB];   // gnt[o][i]
  logic [PORT_NUB-1:0]   acc [PORT_NUB];   // acc[i][o]
  logic [PORT_NUB-1:0]   acc_any;
  logic [WIDTH_SEL-1:0]  acc_out   [PORT_NUB];
  logic [PORT_NUB-1:0]   load;
  logic [WIDTH_SEL-1:0]  load_src  [PORT_NUB];
  logic [WORD_W-1:0]     load_word [PORT_NUB];

  // Index k steps past base, wrapping modulo PORT_NUB (power of two)
  function automatic logic [WIDTH_SEL-1:0] rot(input logic [WIDTH_SEL-1:0] base, input int k);
    return base + WIDTH_SEL'(k);
  endfunction

  // Unpack ingress words and decide which inputs push this cycle
  always_comb begin
    push_q = '0;
    for (int i = 0; i < PORT_NUB; i++) begin
      dest[i]     = in_data[i*WORD_W+DATA_WIDTH +: WIDTH_SEL];
      payload[i]  = in_data[i*WORD_W +: DATA_WIDTH];
      sel_full[i] = (cnt[i*PORT_NUB + int'(dest[i])] == FULL_CNT);
      push[i]     = in_valid[i] & ~sel_full[i];
      for (int d = 0; d < PORT_NUB; d++)
        push_q[i*PORT_NUB+d] = push[i] && (dest[i] == WIDTH_SEL'(d));
    end
  end

`ifdef VOQ_FULL_DROP_EN
  assign in_ready = '1;
`else
  assign in_ready = ~sel_full;
`endif

  // Requests: a VOQ with data asks for an output whose register can take a word
  always_comb begin
    for (int o = 0; o < PORT_NUB; o++)
      slot_free[o] = ~out_vld[o] | out_ready[o];
    for (int i = 0; i < PORT_NUB; i++)
      for (int o = 0; o < PORT_NUB; o++)
        req[i][o] = (cnt[i*PORT_NUB+o] != '0) & slot_free[o];
  end

  // Grant: each output takes the first requester at or after g_ptr
  always_comb begin
    for (int o = 0; o < PORT_NUB; o++) begin
      gnt[o] = '0;
      // Scan backwards so the nearest requester is written last and wins
      for (int k = PORT_NUB-1; k >= 0; k--) begin
        if (req[rot(g_ptr[o], k)][o]) begin
          gnt[o] = '0;
          gnt[o][rot(g_ptr[o], k)] = 1'b1;
        end
      end
    end
  end

  // Accept: each input takes the first granting output at or after a_ptr
  always_comb begin
    for (int i = 0; i < PORT_NUB; i++) begin
      acc[i]     = '0;
      acc_out[i] = '0;
      for (int k = PORT_NUB-1; k >= 0; k--) begin
        if (gnt[rot(a_ptr[i], k)][i]) begin
          acc[i] = '0;
          acc[i][rot(a_ptr[i], k)] = 1'b1;
          acc_out[i] = rot(a_ptr[i], k);
        end
      end
      acc_any[i] = |acc[i];
    end
  end

  // Turn accepted pairs into VOQ pops and output-register loads
  always_comb begin
    load  = '0;
    pop_q = '0;
    for (int o = 0; o < PORT_NUB; o++) begin
      load_src[o]  = '0;
      load_word[o] = '0;
    end
    for (int i = 0; i < PORT_NUB; i++) begin
      for (int o = 0; o < PORT_NUB; o++) begin
        if (acc[i][o]) begin
          load[o]      = 1'b1;
          load_src[o]  = WIDTH_SEL'(i);
          load_word[o] = {WIDTH_SEL'(i), mem[i*PORT_NUB+o][rd_ptr[i*PORT_NUB+o]]};
          pop_q[i*PORT_NUB+o] = 1'b1;
        end
      end
    end
  end

  // VOQ pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < NQ; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        cnt[q]    <= '0;
      end
    end else begin
      for (int q = 0; q < NQ; q++) begin
        if (push_q[q]) wr_ptr[q] <= wr_ptr[q] + PTR_W'(1);
        if (pop_q[q])  rd_ptr[q] <= rd_ptr[q] + PTR_W'(1);
        if (push_q[q] & ~pop_q[q])      cnt[q] <= cnt[q] + (PTR_W+1)'(1);
        else if (~push_q[q] & pop_q[q]) cnt[q] <= cnt[q] - (PTR_W+1)'(1);
      end
    end
  end

  // VOQ payload storage; discarded on reset by clearing the counts
  always_ff @(posedge clk) begin
    for (int i = 0; i < PORT_NUB; i++)
      if (push[i])
        mem[i*PORT_NUB + int'(dest[i])][wr_ptr[i*PORT_NUB + int'(dest[i])]] <= payload[i];
  end

  // Output registers and iSLIP pointers; only accepted pairs move pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= '0;
      for (int o = 0; o < PORT_NUB; o++) begin
        out_reg[o] <= '0;
        g_ptr[o]   <= '0;
        a_ptr[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < PORT_NUB; o++) begin
        if (load[o]) begin
          out_vld[o] <= 1'b1;
          out_reg[o] <= load_word[o];
          g_ptr[o]   <= load_src[o] + WIDTH_SEL'(1);
        end else if (out_ready[o]) begin
          out_vld[o] <= 1'b0;
        end
      end
      for (int i = 0; i < PORT_NUB; i++)
        if (acc_any[i]) a_ptr[i] <= acc_out[i] + WIDTH_SEL'(1);
    end
  end

  // Present registered outputs and VOQ empty flags
  always_comb begin
    for (int o = 0; o < PORT_NUB; o++)
      out_data[o*WORD_W +: WORD_W] = out_reg[o];
    for (int q = 0; q < NQ; q++)
      voq_empty[q] = (cnt[q] == '0);
  end

  assign out_valid = out_vld;

`ifdef VOQ_FULL_DROP_EN
  // Count words discarded against a full VOQ, saturating at all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < PORT_NUB; i++)
        if (in_valid[i] & sel_full[i] & (drop_cnt[i*16 +: 16] != 16'hFFFF))
          drop_cnt[i*16 +: 16] <= drop_cnt[i*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule
